writebuf_merge: RTL and testbench

Parametrised, coalescing write buffer between the data-side cache and the main-memory arbiter. Write-through stores are queued in a DEPTH-entry FIFO and drained to memory one word at a time over the en/done handshake. A store to a word already queued, and not yet in flight, is merged into that entry byte-lane-wise. A combinational read-hazard port lets the cache forward pending store data, or stall, on a read miss.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/wbentry.sv | 53 +++++
 rtl/writebuf_merge.sv | 131 +++++++++++++
 tb/tb_writebuf_merge.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side defaults and bit layout of a packed write-buffer entry {valid, adr, byteen, data}.
package mem_pkg;

  localparam int ADRW_DEF  = 27;
  localparam int DATAW_DEF = 32;

  function automatic int bew_of(input int dataw);
    return dataw / 8;
  endfunction

  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int be_lsb(input int dataw);
    return dataw;
  endfunction

  function automatic int adr_lsb(input int dataw);
    return dataw + bew_of(dataw);
  endfunction

  function automatic int valid_bit(input int adrw, input int dataw);
    return adr_lsb(dataw) + adrw;
  endfunction

  function automatic int entry_w(input int adrw, input int dataw);
    return valid_bit(adrw, dataw) + 1;
  endfunction

  localparam int ENTRY_W_DEF = entry_w(ADRW_DEF, DATAW_DEF);

endpackage

// File: rtl/wbentry.sv
// One write-buffer entry: full overwrite on allocate, byte-lane merge on coalesce, valid clear on retire.
module wbentry
  import mem_pkg::*;
#(
  parameter int ADRW  = ADRW_DEF,
  parameter int DATAW = DATAW_DEF,
  localparam int BEW  = DATAW / 8
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             alloc,
  input  logic             merge,
  input  logic             clear,
  input  logic [ADRW-1:0]  in_adr,
  input  logic [DATAW-1:0] in_data,
  input  logic [BEW-1:0]   in_be,
  output logic             valid,
  output logic [ADRW-1:0]  adr,
  output logic [DATAW-1:0] data,
  output logic [BEW-1:0]   byteen
);

  localparam int EW = entry_w(ADRW, DATAW);
  localparam int DL = data_lsb();
  localparam int BL = be_lsb(DATAW);
  localparam int AL = adr_lsb(DATAW);
  localparam int VB = valid_bit(ADRW, DATAW);

  logic [EW-1:0] ent;

  // The owner never asserts alloc together with merge or clear on the same entry.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      ent <= '0;
    end else if (alloc) begin
      ent <= {1'b1, in_adr, in_be, in_data};
    end else begin
      if (merge) begin
        for (int i = 0; i < BEW; i++) begin
          if (in_be[i]) ent[DL+8*i +: 8] <= in_data[8*i +: 8];
        end
        ent[BL +: BEW] <= ent[BL +: BEW] | in_be;
      end
      if (clear) ent[VB] <= 1'b0;
    end
  end

  assign valid  = ent[VB];
  assign adr    = ent[AL +: ADRW];
  assign byteen = ent[BL +: BEW];
  assign data   = ent[DL +: DATAW];

endmodule

// File: rtl/writebuf_merge.sv
// Coalescing write-through buffer: FIFO of wbentry registers drained to memory over en/done,
// with byte-lane merging into queued non-head entries and a combinational read-hazard port.
module writebuf_merge
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADRW  = ADRW_DEF,
  parameter int DATAW = DATAW_DEF,
  localparam int BEW  = DATAW / 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             wen,
  input  logic [ADRW-1:0]  wadr,
  input  logic [DATAW-1:0] wdata,
  input  logic [BEW-1:0]   wbyteen,
  output logic             wack,
  input  logic             rchk,
  input  logic [ADRW-1:0]  radr,
  input  logic [BEW-1:0]   rbyteen,
  output logic             rhit,
  output logic             rfwd,
  output logic [DATAW-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             memen,
  output logic [ADRW-1:0]  memadr,
  output logic [DATAW-1:0] memdata,
  output logic [BEW-1:0]   membyteen,
  input  logic             memdone
);

  logic [PW-1:0]    wrptr, rdptr;
  logic [CW-1:0]    cnt;
  logic             full, merge, alloc, retire;

  logic [DEPTH-1:0] e_vld, e_alloc, e_merge, e_clear, wmatch, rmatch;
  logic [ADRW-1:0]  e_adr  [DEPTH];
  logic [DATAW-1:0] e_data [DEPTH];
  logic [BEW-1:0]   e_be   [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    wbentry #(.ADRW(ADRW), .DATAW(DATAW)) u_ent (
      .ph1     (ph1),
      .reset   (reset),
      .alloc   (e_alloc[g]),
      .merge   (e_merge[g]),
      .clear   (e_clear[g]),
      .in_adr  (wadr),
      .in_data (wdata),
      .in_be   (wbyteen),
      .valid   (e_vld[g]),
      .adr     (e_adr[g]),
      .data    (e_data[g]),
      .byteen  (e_be[g])
    );

    // The head is already on the memory bus, so it is excluded as a merge target.
    assign wmatch[g]  = e_vld[g] && (e_adr[g] == wadr) && (PW'(g) != rdptr);
    assign rmatch[g]  = e_vld[g] && (e_adr[g] == radr);
    assign e_alloc[g] = alloc && (wrptr == PW'(g));
    assign e_merge[g] = merge && wmatch[g];
    assign e_clear[g] = retire && (rdptr == PW'(g));
  end

  assign full   = (cnt == CW'(DEPTH));
  assign merge  = wen && (|wmatch);
  assign alloc  = wen && !(|wmatch) && !full;
  assign wack   = merge || alloc;
  assign memen  = (cnt != '0);
  assign retire = memen && memdone;
  assign count  = cnt;
  assign empty  = (cnt == '0);

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      wrptr <= '0;
      rdptr <= '0;
      cnt   <= '0;
    end else begin
      if (alloc)  wrptr <= wrptr + 1'b1;
      if (retire) rdptr <= rdptr + 1'b1;
      case ({alloc, retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    memadr    = '0;
    memdata   = '0;
    membyteen = '0;
    if (memen) begin
      memadr    = e_adr[rdptr];
      memdata   = e_data[rdptr];
      membyteen = e_be[rdptr];
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest pending store.
  logic             yhit;
  logic [DATAW-1:0] ydata;
  logic [BEW-1:0]   ybe;
  logic [PW-1:0]    idx;

  always_comb begin
    yhit  = 1'b0;
    ydata = '0;
    ybe   = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rdptr + PW'(k);
      if (rmatch[idx]) begin
        yhit  = 1'b1;
        ydata = e_data[idx];
        ybe   = e_be[idx];
      end
    end
  end

  assign rhit  = rchk && yhit;
  assign rfwd  = rhit && ((rbyteen & ~ybe) == '0);
  assign rdata = rhit ? ydata : '0;

  a_single_merge_target: assert property (@(posedge ph1) disable iff (reset) $onehot0(wmatch));

endmodule

// File: tb/tb_writebuf_merge.sv
// Randomized and directed bench for writebuf_merge against a queue-based reference model.
module tb_writebuf_merge;

  localparam int DEPTH = 4;

  logic        ph1 = 1'b0;
  logic        reset = 1'b1;
  logic        wen = 1'b0;
  logic [26:0] wadr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbyteen = '0;
  logic        wack;
  logic        rchk = 1'b0;
  logic [26:0] radr = '0;
  logic [3:0]  rbyteen = '0;
  logic        rhit, rfwd;
  logic [31:0] rdata;
  logic [2:0]  count;
  logic        empty, memen;
  logic [26:0] memadr;
  logic [31:0] memdata;
  logic [3:0]  membyteen;
  logic        memdone = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 ph1 = ~ph1;

  writebuf_merge #(.DEPTH(DEPTH), .ADRW(27), .DATAW(32)) dut (
    .ph1(ph1), .reset(reset),
    .wen(wen), .wadr(wadr), .wdata(wdata), .wbyteen(wbyteen), .wack(wack),
    .rchk(rchk), .radr(radr), .rbyteen(rbyteen),
    .rhit(rhit), .rfwd(rfwd), .rdata(rdata),
    .count(count), .empty(empty),
    .memen(memen), .memadr(memadr), .memdata(memdata), .membyteen(membyteen),
    .memdone(memdone)
  );

  typedef struct {
    logic [26:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
  } ment_t;

  ment_t q[$];

  logic        obs_wack, obs_rhit, obs_rfwd;
  logic [31:0] obs_rdata;

  // One clock cycle: drive, compare every output against the model, take the edge, advance the model.
  task automatic cyc(input logic w, input logic [26:0] a, input logic [31:0] d, input logic [3:0] b,
                     input logic md, input logic rc, input logic [26:0] ra, input logic [3:0] rb);
    int mj;
    int sz;
    logic        e_wack, e_rhit, e_rfwd, e_memen;
    logic [31:0] e_rdata, e_mdata;
    logic [26:0] e_madr;
    logic [3:0]  e_mbe, yb;
    ment_t       n;
    @(negedge ph1);
    wen = w; wadr = a; wdata = d; wbyteen = b; memdone = md;
    rchk = rc; radr = ra; rbyteen = rb;
    #1;
    sz = q.size();
    mj = -1;
    for (int j = 1; j < sz; j++) if (q[j].adr == a) mj = j;
    e_wack = w && (mj >= 0 || sz < DEPTH);
    e_rhit = 1'b0; e_rdata = '0; yb = '0;
    if (rc) for (int j = 0; j < sz; j++) if (q[j].adr == ra) begin
      e_rhit = 1'b1; e_rdata = q[j].data; yb = q[j].be;
    end
    e_rfwd  = e_rhit && ((rb & ~yb) == 4'b0);
    e_memen = (sz > 0);
    e_madr  = e_memen ? q[0].adr  : '0;
    e_mdata = e_memen ? q[0].data : '0;
    e_mbe   = e_memen ? q[0].be   : '0;
    checks += 10;
    if (wack !== e_wack)           begin errors++; $display("FAIL wack got %b exp %b t=%0t", wack, e_wack, $time); end
    if (rhit !== e_rhit)           begin errors++; $display("FAIL rhit got %b exp %b t=%0t", rhit, e_rhit, $time); end
    if (rfwd !== e_rfwd)           begin errors++; $display("FAIL rfwd got %b exp %b t=%0t", rfwd, e_rfwd, $time); end
    if (rdata !== e_rdata)         begin errors++; $display("FAIL rdata got %h exp %h t=%0t", rdata, e_rdata, $time); end
    if (memen !== e_memen)         begin errors++; $display("FAIL memen got %b exp %b t=%0t", memen, e_memen, $time); end
    if (memadr !== e_madr)         begin errors++; $display("FAIL memadr got %h exp %h t=%0t", memadr, e_madr, $time); end
    if (memdata !== e_mdata)       begin errors++; $display("FAIL memdata got %h exp %h t=%0t", memdata, e_mdata, $time); end
    if (membyteen !== e_mbe)       begin errors++; $display("FAIL membyteen got %b exp %b t=%0t", membyteen, e_mbe, $time); end
    if (count !== 3'(sz))          begin errors++; $display("FAIL count got %0d exp %0d t=%0t", count, sz, $time); end
    if (empty !== (sz == 0))       begin errors++; $display("FAIL empty got %b exp %b t=%0t", empty, (sz == 0), $time); end
    obs_wack = wack; obs_rhit = rhit; obs_rfwd = rfwd; obs_rdata = rdata;
    @(posedge ph1);
    if (w && mj >= 0) begin
      for (int i = 0; i < 4; i++) if (b[i]) q[mj].data[8*i +: 8] = d[8*i +: 8];
      q[mj].be = q[mj].be | b;
    end
    if (md && sz > 0) void'(q.pop_front());
    if (w && mj < 0 && sz < DEPTH) begin
      n.adr = a; n.data = d; n.be = b;
      q.push_back(n);
    end
    #1;
  endtask

  task automatic wr(input logic [26:0] a, input logic [31:0] d, input logic [3:0] b);
    cyc(1'b1, a, d, b, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input logic md);
    cyc(1'b0, '0, '0, '0, md, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge ph1);
    reset = 1'b1; wen = 1'b0; memdone = 1'b0; rchk = 1'b0;
    q.delete();
    @(negedge ph1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 6;
    if (memen !== 1'b0)   begin errors++; $display("FAIL reset_memen got %b exp 0", memen); end
    if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    if (count !== 3'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    if (memadr !== '0)    begin errors++; $display("FAIL reset_memadr got %h exp 0", memadr); end
    if (rhit !== 1'b0)    begin errors++; $display("FAIL reset_rhit got %b exp 0", rhit); end
    if (rdata !== '0)     begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
  endtask

  task automatic test_basic();
    do_reset();
    wr(27'h4AD, 32'hDDCCBBAA, 4'hF);
    checks += 3;
    if (obs_wack !== 1'b1)     begin errors++; $display("FAIL basic_wack got %b exp 1", obs_wack); end
    if (memen !== 1'b1)        begin errors++; $display("FAIL basic_memen got %b exp 1", memen); end
    if (memadr !== 27'h4AD)    begin errors++; $display("FAIL basic_memadr got %h exp 4ad", memadr); end
    idle(1'b1);
    checks++;
    if (empty !== 1'b1)        begin errors++; $display("FAIL basic_empty got %b exp 1", empty); end
  endtask

  task automatic test_full_merge();
    do_reset();
    for (int i = 0; i < 4; i++) wr(27'h10 + 27'(i), 32'h01010101 * 32'(i + 1), 4'hF);
    checks++;
    if (count !== 3'd4)    begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    wr(27'h20, 32'h12345678, 4'hF);
    checks++;
    if (obs_wack !== 1'b0) begin errors++; $display("FAIL full_drop got %b exp 0", obs_wack); end
    wr(27'h12, 32'hCAFEF00D, 4'h5);
    checks += 2;
    if (obs_wack !== 1'b1) begin errors++; $display("FAIL full_merge_wack got %b exp 1", obs_wack); end
    if (count !== 3'd4)    begin errors++; $display("FAIL full_merge_count got %0d exp 4", count); end
  endtask

  task automatic test_merge_and_hazard();
    do_reset();
    wr(27'h10, 32'h11111111, 4'hF);
    wr(27'h11, 32'h0000BBAA, 4'h3);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 27'h11, 4'h1);
    checks += 3;
    if (obs_rhit !== 1'b1)          begin errors++; $display("FAIL hz_lane_rhit got %b exp 1", obs_rhit); end
    if (obs_rfwd !== 1'b1)          begin errors++; $display("FAIL hz_lane_rfwd got %b exp 1", obs_rfwd); end
    if (obs_rdata[7:0] !== 8'hAA)   begin errors++; $display("FAIL hz_lane_rdata got %h exp aa", obs_rdata[7:0]); end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 27'h11, 4'hF);
    checks += 2;
    if (obs_rhit !== 1'b1)          begin errors++; $display("FAIL hz_full_rhit got %b exp 1", obs_rhit); end
    if (obs_rfwd !== 1'b0)          begin errors++; $display("FAIL hz_full_rfwd got %b exp 0", obs_rfwd); end
    wr(27'h11, 32'hDDCC0000, 4'hC);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 27'h11, 4'hF);
    checks += 3;
    if (obs_rfwd !== 1'b1)          begin errors++; $display("FAIL merge_rfwd got %b exp 1", obs_rfwd); end
    if (obs_rdata !== 32'hDDCCBBAA) begin errors++; $display("FAIL merge_rdata got %h exp ddccbbaa", obs_rdata); end
    if (count !== 3'd2)             begin errors++; $display("FAIL merge_count got %0d exp 2", count); end
    wr(27'h10, 32'h22222222, 4'hF);
    checks++;
    if (count !== 3'd3)             begin errors++; $display("FAIL head_nomerge_count got %0d exp 3", count); end
  endtask

  task automatic test_full_retire_reset();
    do_reset();
    for (int i = 0; i < 4; i++) wr(27'h40 + 27'(i), $urandom, 4'hF);
    cyc(1'b1, 27'h50, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, '0, '0);
    checks += 2;
    if (obs_wack !== 1'b0) begin errors++; $display("FAIL nobypass_wack got %b exp 0", obs_wack); end
    if (count !== 3'd3)    begin errors++; $display("FAIL nobypass_count got %0d exp 3", count); end
    @(negedge ph1);
    wen = 1'b0; memdone = 1'b0;
    reset = 1'b1;
    #1;
    checks += 2;
    if (memen !== 1'b0)    begin errors++; $display("FAIL midreset_memen got %b exp 0", memen); end
    if (count !== 3'd0)    begin errors++; $display("FAIL midreset_count got %0d exp 0", count); end
    q.delete();
    @(negedge ph1);
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 9) < 6), 27'($urandom_range(0, 5)), $urandom, 4'($urandom_range(1, 15)),
          ($urandom_range(0, 9) < 3), 1'($urandom), 27'($urandom_range(0, 5)), 4'($urandom_range(1, 15)));
    end
    for (int n = 0; n < 8; n++) idle(1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_merge();
    test_merge_and_hazard();
    test_full_retire_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
